// File: rtl/cube_scan_driver.sv
// cube_scan_driver
// Multiplexed scan driver for an N x N x N LED cube. The cube is lit one row
// at a time: one layer is pulled low on high_csn, one row is selected on
// row_cs, and the row's LED bits go out on row. Each row slot starts with a
// blanking interval where everything is off, then an on interval where the
// row data is gated by a PWM comparison against a latched brightness.
// Frames are double buffered: a new frame lands in a shadow buffer and is
// copied into the displayed buffer only at the end of a full scan.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   enable       scanning enabled when high
//   brightness   global PWM duty (lit when pwm count < brightness)
//   frame_flat   new frame; row r occupies bits [r*N+N-1 : r*N]
//   frame_valid  frame_flat offered
//   frame_ready  shadow buffer empty, offered frame is accepted
//   high_csn     layer select, active low
//   row_cs       row select, active high
//   row          LED data of the selected row
//   frame_done   one-cycle pulse after the last slot of a full scan
module cube_scan_driver #(
  parameter int N            = 8,
  parameter int ROW_CYCLES   = 16384,
  parameter int BLANK_CYCLES = 64,
  parameter int BRIGHT_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [BRIGHT_W-1:0] brightness,
  input  logic [N*N*N-1:0]    frame_flat,
  input  logic                frame_valid,
  output logic                frame_ready,
  output logic [N-1:0]        high_csn,
  output logic [N-1:0]        row_cs,
  output logic [N-1:0]        row,
  output logic                frame_done
);

  localparam int LOGN   = $clog2(N);
  localparam int IDX_W  = 2 * LOGN;
  localparam int SLOT_W = $clog2(ROW_CYCLES);
  localparam int CUBE   = N * N * N;

  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(ROW_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = {IDX_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t              state_r, state_nxt;
  logic [IDX_W-1:0]    idx_r, idx_nxt;
  logic [SLOT_W-1:0]   slot_r, slot_nxt;
  logic [BRIGHT_W-1:0] pwm_r, pwm_nxt;
  logic [BRIGHT_W-1:0] bright_r, bright_nxt;
  logic                wrap;

  logic [CUBE-1:0]     active_r;
  logic [CUBE-1:0]     shadow_r;
  logic                shadow_full_r;
  logic                load;

  logic [N-1:0]        csn_nxt, cs_nxt, row_nxt;
  logic [LOGN-1:0]     layer, lrow;

  // idx = layer * N + row-in-layer, so the split is a plain bit slice
  assign layer       = idx_r[IDX_W-1:LOGN];
  assign lrow        = idx_r[LOGN-1:0];
  assign frame_ready = ~shadow_full_r;
  assign load        = frame_valid & ~shadow_full_r;

  // Scan state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= {IDX_W{1'b0}};
      slot_r   <= {SLOT_W{1'b0}};
      pwm_r    <= {BRIGHT_W{1'b0}};
      bright_r <= {BRIGHT_W{1'b0}};
    end else begin
      state_r  <= state_nxt;
      idx_r    <= idx_nxt;
      slot_r   <= slot_nxt;
      pwm_r    <= pwm_nxt;
      bright_r <= bright_nxt;
    end
  end

  // Next-state logic: slot timing, row index advance, PWM count, brightness latch
  always_comb begin
    state_nxt  = state_r;
    idx_nxt    = idx_r;
    slot_nxt   = slot_r;
    pwm_nxt    = pwm_r;
    bright_nxt = bright_r;
    wrap       = 1'b0;
    if (!enable) begin
      // dropping enable abandons the scan without a frame end
      state_nxt = IDLE;
      idx_nxt   = {IDX_W{1'b0}};
      slot_nxt  = {SLOT_W{1'b0}};
      pwm_nxt   = {BRIGHT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt  = BLANK;
          idx_nxt    = {IDX_W{1'b0}};
          slot_nxt   = {SLOT_W{1'b0}};
          pwm_nxt    = {BRIGHT_W{1'b0}};
          bright_nxt = brightness;
        end
        BLANK: begin
          slot_nxt = slot_r + 1'b1;
          pwm_nxt  = {BRIGHT_W{1'b0}};
          if (slot_r == BLANK_LAST) begin
            state_nxt = ON;
          end else begin
            state_nxt = BLANK;
          end
        end
        ON: begin
          pwm_nxt = pwm_r + 1'b1;
          if (slot_r == SLOT_LAST) begin
            state_nxt  = BLANK;
            slot_nxt   = {SLOT_W{1'b0}};
            bright_nxt = brightness;
            // N*N is a power of two, so the increment wraps idx to 0 by itself
            idx_nxt    = idx_r + 1'b1;
            wrap       = (idx_r == IDX_LAST);
          end else begin
            state_nxt = ON;
            slot_nxt  = slot_r + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = {IDX_W{1'b0}};
          slot_nxt  = {SLOT_W{1'b0}};
          pwm_nxt   = {BRIGHT_W{1'b0}};
        end
      endcase
    end
  end

  // Output decode from current state; registered below so outputs lag by one cycle
  always_comb begin
    csn_nxt = {N{1'b1}};
    cs_nxt  = {N{1'b0}};
    row_nxt = {N{1'b0}};
    case (state_r)
      ON: begin
        for (int i = 0; i < N; i++) begin
          csn_nxt[i] = (layer != LOGN'(i));
          cs_nxt[i]  = (lrow == LOGN'(i));
        end
        if (pwm_r < bright_r) begin
          row_nxt = active_r[{idx_r, {LOGN{1'b0}}} +: N];
        end else begin
          row_nxt = {N{1'b0}};
        end
      end
      default: begin
        csn_nxt = {N{1'b1}};
        cs_nxt  = {N{1'b0}};
        row_nxt = {N{1'b0}};
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      high_csn   <= {N{1'b1}};
      row_cs     <= {N{1'b0}};
      row        <= {N{1'b0}};
      frame_done <= 1'b0;
    end else begin
      high_csn   <= csn_nxt;
      row_cs     <= cs_nxt;
      row        <= row_nxt;
      frame_done <= wrap;
    end
  end

  // Double-buffered frame storage; the swap happens only on the frame-end edge.
  // A load can never coincide with the swap because load requires an empty shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r      <= {CUBE{1'b0}};
      shadow_r      <= {CUBE{1'b0}};
      shadow_full_r <= 1'b0;
    end else begin
      if (wrap && shadow_full_r) begin
        active_r      <= shadow_r;
        shadow_full_r <= 1'b0;
      end
      if (load) begin
        shadow_r      <= frame_flat;
        shadow_full_r <= 1'b1;
      end
    end
  end

endmodule
